// File: rtl/int_img_window_scan.sv
// Scans a WINDOW x WINDOW box over an integral image and its squared twin in row-major order.
// Emits the box sum, squared sum and N*sq_sum - sum^2 through a two-stage valid/ready pipeline.
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 320
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 240
`endif

module int_img_window_scan #(
  parameter int WIDTH_LIMIT  = `LAPTOP_WIDTH,
  parameter int HEIGHT_LIMIT = `LAPTOP_HEIGHT,
  parameter int WINDOW       = 24,
  parameter int STEP         = 1,
  localparam int RW = (HEIGHT_LIMIT > 1) ? $clog2(HEIGHT_LIMIT) : 1,
  localparam int CW = (WIDTH_LIMIT > 1) ? $clog2(WIDTH_LIMIT) : 1
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0][31:0] int_img,
  input  logic [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0][31:0] int_img_sq,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [RW-1:0]                                 out_row,
  output logic [CW-1:0]                                 out_col,
  output logic [31:0]                                   out_sum,
  output logic [31:0]                                   out_sq_sum,
  output logic [63:0]                                   out_var,
  output logic                                          busy,
  output logic                                          done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t        state;
  logic [RW-1:0] r;
  logic [CW-1:0] c;

  logic          s1_valid;
  logic [RW-1:0] s1_row;
  logic [CW-1:0] s1_col;
  logic [31:0]   s1_sum;
  logic [31:0]   s1_sq;

  logic          stall;
  logic          r_last;
  logic          c_last;
  logic [RW-1:0] rb;
  logic [RW-1:0] rt;
  logic [CW-1:0] cr;
  logic [CW-1:0] cl;
  logic [31:0]   win_sum;
  logic [31:0]   win_sq;
  logic [63:0]   var_next;

  assign stall  = out_valid & ~out_ready;
  assign r_last = (32'(r) + 32'(STEP)) > 32'(HEIGHT_LIMIT - WINDOW);
  assign c_last = (32'(c) + 32'(STEP)) > 32'(WIDTH_LIMIT - WINDOW);

  // Corners above/left of the image are treated as zero; rt/cl are clamped
  // so the unused reads never index outside the array.
  always_comb begin
    rb      = r + RW'(WINDOW - 1);
    cr      = c + CW'(WINDOW - 1);
    rt      = (r == '0) ? '0 : r - RW'(1);
    cl      = (c == '0) ? '0 : c - CW'(1);
    win_sum = int_img[rb][cr];
    win_sq  = int_img_sq[rb][cr];
    if (r != '0) begin
      win_sum = win_sum - int_img[rt][cr];
      win_sq  = win_sq - int_img_sq[rt][cr];
    end
    if (c != '0) begin
      win_sum = win_sum - int_img[rb][cl];
      win_sq  = win_sq - int_img_sq[rb][cl];
    end
    if ((r != '0) && (c != '0)) begin
      win_sum = win_sum + int_img[rt][cl];
      win_sq  = win_sq + int_img_sq[rt][cl];
    end
  end

  assign var_next = 64'(s1_sq) * 64'(WINDOW * WINDOW) - 64'(s1_sum) * 64'(s1_sum);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      r          <= '0;
      c          <= '0;
      s1_valid   <= 1'b0;
      s1_row     <= '0;
      s1_col     <= '0;
      s1_sum     <= '0;
      s1_sq      <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      out_sum    <= '0;
      out_sq_sum <= '0;
      out_var    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!stall) begin
        out_valid  <= s1_valid;
        out_row    <= s1_row;
        out_col    <= s1_col;
        out_sum    <= s1_sum;
        out_sq_sum <= s1_sq;
        out_var    <= var_next;
        s1_valid   <= 1'b0;
        case (state)
          IDLE: begin
            if (start) begin
              state <= SCAN;
              busy  <= 1'b1;
              r     <= '0;
              c     <= '0;
            end
          end
          SCAN: begin
            s1_valid <= 1'b1;
            s1_row   <= r;
            s1_col   <= c;
            s1_sum   <= win_sum;
            s1_sq    <= win_sq;
            if (c_last) begin
              c <= '0;
              if (r_last) state <= DRAIN;
              else        r     <= RW'(32'(r) + 32'(STEP));
            end else begin
              c <= CW'(32'(c) + 32'(STEP));
            end
          end
          DRAIN: begin
            // S1 is empty once the final result sits in the output stage.
            if (out_valid && out_ready && !s1_valid) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_int_img_window_scan.sv
// Bench for int_img_window_scan on a 4x4 image with a 2x2 window, stride 1 and stride 2.
// Expected results come from direct summation over the pixel array.
module tb_int_img_window_scan;

  localparam int H   = 4;
  localparam int W   = 4;
  localparam int WIN = 2;
  localparam int N   = WIN * WIN;

  typedef struct {
    int          row;
    int          col;
    logic [31:0] sum;
    logic [31:0] sq;
    logic [63:0] v;
  } res_t;

  typedef struct {
    int img_kind;
    int inst;
    int exp_count;
  } scen_t;

  typedef struct {
    int          idx;
    int          row;
    int          col;
    logic [31:0] sum;
    logic [31:0] sq;
    logic [63:0] v;
  } spot_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [H-1:0][W-1:0][31:0] int_img;
  logic [H-1:0][W-1:0][31:0] int_img_sq;
  int pix [H][W];

  logic        start_a, ready_a, valid_a, busy_a, done_a;
  logic [1:0]  row_a, col_a;
  logic [31:0] sum_a, sq_a;
  logic [63:0] var_a;
  logic        start_b, ready_b, valid_b, busy_b, done_b;
  logic [1:0]  row_b, col_b;
  logic [31:0] sum_b, sq_b;
  logic [63:0] var_b;

  int_img_window_scan #(.WIDTH_LIMIT(W), .HEIGHT_LIMIT(H), .WINDOW(WIN), .STEP(1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .int_img(int_img), .int_img_sq(int_img_sq),
    .out_valid(valid_a), .out_ready(ready_a), .out_row(row_a), .out_col(col_a),
    .out_sum(sum_a), .out_sq_sum(sq_a), .out_var(var_a), .busy(busy_a), .done(done_a)
  );

  int_img_window_scan #(.WIDTH_LIMIT(W), .HEIGHT_LIMIT(H), .WINDOW(WIN), .STEP(2)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .int_img(int_img), .int_img_sq(int_img_sq),
    .out_valid(valid_b), .out_ready(ready_b), .out_row(row_b), .out_col(col_b),
    .out_sum(sum_b), .out_sq_sum(sq_b), .out_var(var_b), .busy(busy_b), .done(done_b)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  res_t q_a[$];
  res_t q_b[$];
  res_t log_a[16];
  int   cnt_a = 0, cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  int   first_hs_a = 0, last_hs_a = 0, done_cyc_a = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t model(input int r, input int c);
    res_t x;
    x.row = r;
    x.col = c;
    x.sum = '0;
    x.sq  = '0;
    for (int i = 0; i < WIN; i++)
      for (int j = 0; j < WIN; j++) begin
        x.sum = x.sum + 32'(pix[r+i][c+j]);
        x.sq  = x.sq + 32'(pix[r+i][c+j] * pix[r+i][c+j]);
      end
    x.v = 64'(N) * {32'b0, x.sq} - {32'b0, x.sum} * {32'b0, x.sum};
    return x;
  endfunction

  task automatic set_image(input int kind);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        pix[i][j] = (kind == 0) ? 4 * i + j : 1;
    for (int p = 0; p < H; p++)
      for (int o = 0; o < W; o++) begin
        int s = 0;
        int sq = 0;
        for (int i = 0; i <= p; i++)
          for (int j = 0; j <= o; j++) begin
            s  += pix[i][j];
            sq += pix[i][j] * pix[i][j];
          end
        int_img[p][o]    = 32'(s);
        int_img_sq[p][o] = 32'(sq);
      end
  endtask

  task automatic push_scan(input int inst, input int step);
    for (int r = 0; r <= H - WIN; r += step)
      for (int c = 0; c <= W - WIN; c += step)
        if (inst == 0) q_a.push_back(model(r, c));
        else           q_b.push_back(model(r, c));
  endtask

  task automatic start_scan(input int inst, input int step);
    if (inst == 0) begin cnt_a = 0; done_cnt_a = 0; end
    else           begin cnt_b = 0; done_cnt_b = 0; end
    push_scan(inst, step);
    @(posedge clock); #1;
    if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input int inst, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if ((inst == 0 && !busy_a) || (inst == 1 && !busy_b)) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clock);
    check("scan_finished", 64'(ok), 64'd1);
  endtask

  always @(negedge clock) begin : mon_a
    res_t e;
    res_t g;
    if (!reset && done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (!reset && valid_a && ready_a) begin
      g.row = int'(row_a);
      g.col = int'(col_a);
      g.sum = sum_a;
      g.sq  = sq_a;
      g.v   = var_a;
      if (cnt_a < 16) log_a[cnt_a] = g;
      if (cnt_a == 0) first_hs_a = cyc;
      last_hs_a = cyc;
      cnt_a++;
      if (q_a.size() == 0) check("extra_result_a", 64'd1, 64'd0);
      else begin
        e = q_a.pop_front();
        check("row_a", 64'(g.row), 64'(e.row));
        check("col_a", 64'(g.col), 64'(e.col));
        check("sum_a", 64'(g.sum), 64'(e.sum));
        check("sq_a", 64'(g.sq), 64'(e.sq));
        check("var_a", g.v, e.v);
      end
    end
  end

  always @(negedge clock) begin : mon_b
    res_t e;
    if (!reset && done_b) done_cnt_b++;
    if (!reset && valid_b && ready_b) begin
      cnt_b++;
      if (q_b.size() == 0) check("extra_result_b", 64'd1, 64'd0);
      else begin
        e = q_b.pop_front();
        check("row_b", 64'(row_b), 64'(e.row));
        check("col_b", 64'(col_b), 64'(e.col));
        check("sum_b", 64'(sum_b), 64'(e.sum));
        check("sq_b", 64'(sq_b), 64'(e.sq));
        check("var_b", var_b, e.v);
      end
    end
  end

  initial begin
    scen_t       scen [3];
    spot_t       spots [2];
    logic [1:0]  fr_row, fr_col;
    logic [31:0] fr_sum;
    logic [63:0] fr_var;

    scen  = '{'{0, 0, 9}, '{1, 0, 9}, '{0, 1, 4}};
    spots = '{'{0, 0, 0, 32'd10, 32'd42, 64'd68}, '{8, 2, 2, 32'd50, 32'd642, 64'd68}};

    start_a = 1'b0;
    start_b = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    set_image(0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_valid_a", 64'(valid_a), 64'd0);
    check("reset_busy_a", 64'(busy_a), 64'd0);
    check("reset_done_a", 64'(done_a), 64'd0);
    check("reset_sum_a", 64'(sum_a), 64'd0);
    check("reset_var_a", var_a, 64'd0);
    check("reset_valid_b", 64'(valid_b), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Full scans: stride 1 ramp, stride 1 all-ones, stride 2 ramp
    for (int s = 0; s < 3; s++) begin
      set_image(scen[s].img_kind);
      start_scan(scen[s].inst, (scen[s].inst == 0) ? 1 : 2);
      if (s == 0) begin
        @(posedge clock); #1;
        check("latency_not_yet", 64'(valid_a), 64'd0);
        @(posedge clock); #1;
        check("latency_valid", 64'(valid_a), 64'd1);
      end
      wait_idle(scen[s].inst, 200);
      check("result_count", 64'((scen[s].inst == 0) ? cnt_a : cnt_b), 64'(scen[s].exp_count));
      check("done_pulses", 64'((scen[s].inst == 0) ? done_cnt_a : done_cnt_b), 64'd1);
      check("queue_empty", 64'((scen[s].inst == 0) ? q_a.size() : q_b.size()), 64'd0);
      if (s == 0) begin
        for (int k = 0; k < 2; k++) begin
          check("spot_row", 64'(log_a[spots[k].idx].row), 64'(spots[k].row));
          check("spot_col", 64'(log_a[spots[k].idx].col), 64'(spots[k].col));
          check("spot_sum", 64'(log_a[spots[k].idx].sum), 64'(spots[k].sum));
          check("spot_sq", 64'(log_a[spots[k].idx].sq), 64'(spots[k].sq));
          check("spot_var", log_a[spots[k].idx].v, spots[k].v);
        end
        check("no_bubbles", 64'(last_hs_a - first_hs_a), 64'd8);
        check("done_timing", 64'(done_cyc_a - last_hs_a), 64'd1);
      end
    end

    // Backpressure: out_ready low for 5 cycles mid-scan
    set_image(0);
    start_scan(0, 1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (cnt_a >= 3) break;
    end
    @(posedge clock); #1;
    ready_a = 1'b0;
    @(negedge clock);
    check("stall_valid", 64'(valid_a), 64'd1);
    fr_row = row_a;
    fr_col = col_a;
    fr_sum = sum_a;
    fr_var = var_a;
    repeat (4) begin
      @(negedge clock);
      check("stall_valid_hold", 64'(valid_a), 64'd1);
      check("stall_row_hold", 64'(row_a), 64'(fr_row));
      check("stall_col_hold", 64'(col_a), 64'(fr_col));
      check("stall_sum_hold", 64'(sum_a), 64'(fr_sum));
      check("stall_var_hold", var_a, fr_var);
    end
    @(posedge clock); #1;
    ready_a = 1'b1;
    wait_idle(0, 200);
    check("stall_count", 64'(cnt_a), 64'd9);
    check("stall_done", 64'(done_cnt_a), 64'd1);

    // start pulsed while busy is ignored; a fresh start afterwards rescans
    start_scan(0, 1);
    repeat (3) @(posedge clock);
    #1;
    start_a = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    start_a = 1'b0;
    check("busy_mid_scan", 64'(busy_a), 64'd1);
    wait_idle(0, 200);
    repeat (4) @(negedge clock);
    check("ignored_start_count", 64'(cnt_a), 64'd9);
    check("ignored_start_done", 64'(done_cnt_a), 64'd1);
    start_scan(0, 1);
    wait_idle(0, 200);
    check("restart_count", 64'(cnt_a), 64'd9);

    // Asynchronous reset after the 4th result aborts the scan
    start_scan(0, 1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (cnt_a >= 4) break;
    end
    #2;
    reset = 1'b1;
    #1;
    check("abort_valid", 64'(valid_a), 64'd0);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_done", 64'(done_a), 64'd0);
    q_a.delete();
    @(negedge clock);
    reset = 1'b0;
    check("abort_no_done", 64'(done_cnt_a), 64'd0);
    start_scan(0, 1);
    wait_idle(0, 200);
    check("after_reset_count", 64'(cnt_a), 64'd9);
    check("after_reset_first_row", 64'(log_a[0].row), 64'd0);
    check("after_reset_first_col", 64'(log_a[0].col), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
